// File: rtl/dac8531_frame_receiver.sv
// DAC8531-style serial frame receiver: samples CS/SCLK/SDI on CLK and captures FRAME_BITS-long frames.
// Optional macro DAC8531_RX_SYNC_EN selects a two-flop input synchronizer instead of a single register.
module dac8531_frame_receiver #(
    parameter int FRAME_BITS = 24
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        DA_CS,
    input  logic        DA_SCLK,
    input  logic        DA_SDI,
    output logic [23:0] RX_DATA,
    output logic [15:0] RX_CODE,
    output logic [1:0]  RX_PD,
    output logic        RX_VALID,
    output logic        RX_ERR,
    output logic        BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic s_cs, s_sclk, s_sdi;
    logic h_cs, h_sclk;

`ifdef DAC8531_RX_SYNC_EN
    localparam int STAGES = 2;

    logic cs_meta, sclk_meta, sdi_meta;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cs_meta   <= 1'b1;
            sclk_meta <= 1'b0;
            sdi_meta  <= 1'b0;
            s_cs      <= 1'b1;
            s_sclk    <= 1'b0;
            s_sdi     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge input; blocking here would collapse the chain.
            cs_meta   <= DA_CS;
            sclk_meta <= DA_SCLK;
            sdi_meta  <= DA_SDI;
            s_cs      <= cs_meta;
            s_sclk    <= sclk_meta;
            s_sdi     <= sdi_meta;
        end
    end
`else
    localparam int STAGES = 1;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s_cs   <= 1'b1;
            s_sclk <= 1'b0;
            s_sdi  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge input.
            s_cs   <= DA_CS;
            s_sclk <= DA_SCLK;
            s_sdi  <= DA_SDI;
        end
    end
`endif

    // Fills with ones after reset; the history register holds real input only once the top bit is set,
    // so a CS already low at reset release is not mistaken for a falling edge.
    logic [STAGES:0] fill;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            h_cs   <= 1'b1;
            h_sclk <= 1'b0;
            fill   <= '0;
        end else begin
            h_cs   <= s_cs;
            h_sclk <= s_sclk;
            fill   <= {fill[STAGES-1:0], 1'b1};
        end
    end

    logic cs_fall, cs_rise, sclk_rise;

    assign cs_fall   = fill[STAGES] & h_cs & ~s_cs;
    assign cs_rise   = ~h_cs & s_cs;
    assign sclk_rise = ~h_sclk & s_sclk;

    state_t      state;
    logic [23:0] shreg;
    logic [4:0]  bit_cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            RX_ERR   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            RX_ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                        BUSY    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // CS release wins over a coincident SCLK edge.
                    if (cs_rise) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        if (bit_cnt == FRAME_CNT) begin
                            RX_DATA  <= shreg;
                            RX_VALID <= 1'b1;
                        end else begin
                            RX_ERR <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shreg <= {shreg[22:0], s_sdi};
                        if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    assign RX_CODE = RX_DATA[15:0];
    assign RX_PD   = RX_DATA[17:16];

endmodule

// File: tb/tb_dac8531_frame_receiver.sv
// Self-checking bench for dac8531_frame_receiver: directed and random frames against a frame-level model.
module tb_dac8531_frame_receiver;

    localparam int FB = 24;
`ifdef DAC8531_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, sclk, sdi;
    logic [23:0] rx_data;
    logic [15:0] rx_code;
    logic [1:0]  rx_pd;
    logic        rx_valid, rx_err, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit          v;
        bit          e;
        int          c;
        logic [23:0] d;
        logic [15:0] code;
        logic [1:0]  pd;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    logic [23:0] exp_data;

    dac8531_frame_receiver #(.FRAME_BITS(FB)) dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .DA_CS    (cs),
        .DA_SCLK  (sclk),
        .DA_SDI   (sdi),
        .RX_DATA  (rx_data),
        .RX_CODE  (rx_code),
        .RX_PD    (rx_pd),
        .RX_VALID (rx_valid),
        .RX_ERR   (rx_err),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid || rx_err) begin
            ev_t ev;
            ev.v = rx_valid; ev.e = rx_err; ev.c = cyc;
            ev.d = rx_data; ev.code = rx_code; ev.pd = rx_pd;
            obs_q.push_back(ev);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [63:0] value, input int nbits, input int lo, input int hi);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk = 1'b0;
            sdi  = value[i];
            tick(lo);
            sclk = 1'b1;
            tick(hi);
        end
    endtask

    // Frame-level model: a frame is accepted only with exactly FB bits; data is the last FB bits sent.
    task automatic send_frame(input logic [63:0] value, input int nbits, input int lo, input int hi,
                              input int cs_hi);
        ev_t ev;
        int  k;
        cs = 1'b0;
        if (nbits == 0) tick(1);
        shift_bits(value, nbits, lo, hi);
        if (nbits >= 2) check("busy_in_frame", 64'(busy), 64'd1);
        sclk = 1'b0;
        cs   = 1'b1;
        k    = cyc + 1;
        tick(cs_hi);
        ev.v = (nbits == FB);
        ev.e = !ev.v;
        ev.c = k + LAT;
        if (ev.v) exp_data = value[23:0];
        ev.d    = exp_data;
        ev.code = exp_data[15:0];
        ev.pd   = exp_data[17:16];
        exp_q.push_back(ev);
    endtask

    task automatic drain(input string tag);
        int n;
        tick(LAT + 3);
        check($sformatf("%s:events", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]:valid", tag, i), 64'(obs_q[i].v), 64'(exp_q[i].v));
            check($sformatf("%s[%0d]:err", tag, i), 64'(obs_q[i].e), 64'(exp_q[i].e));
            check($sformatf("%s[%0d]:cycle", tag, i), 64'(obs_q[i].c), 64'(exp_q[i].c));
            check($sformatf("%s[%0d]:data", tag, i), 64'(obs_q[i].d), 64'(exp_q[i].d));
            check($sformatf("%s[%0d]:code", tag, i), 64'(obs_q[i].code), 64'(exp_q[i].code));
            check($sformatf("%s[%0d]:pd", tag, i), 64'(obs_q[i].pd), 64'(exp_q[i].pd));
        end
        check($sformatf("%s:held_data", tag), 64'(rx_data), 64'(exp_data));
        check($sformatf("%s:idle", tag), 64'(busy), 64'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; sdi = 1'b0;
        exp_data = '0;
        tick(3);
        check("reset:data", 64'(rx_data), 64'd0);
        check("reset:valid", 64'(rx_valid), 64'd0);
        check("reset:err", 64'(rx_err), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick(3);

        send_frame(64'h00ABCD, 24, 1, 1, 2);
        drain("abcd");
        send_frame(64'h03FFFF, 24, 1, 1, 2);
        drain("pd11");
        send_frame(64'h5A5A5A, 23, 1, 1, 2);
        drain("short23");
        send_frame(64'h1C3C3C3, 25, 1, 1, 2);
        drain("long25");
        send_frame(64'h7_1234_5678, 35, 1, 1, 2);
        drain("saturate35");
        send_frame(64'h0, 0, 1, 1, 2);
        drain("empty");

        // Reset mid-frame, released with CS still low: no pulse, no frame start until a new CS fall.
        cs = 1'b0;
        shift_bits(64'h2AB, 10, 1, 1);
        rst_n = 1'b0;
        sclk  = 1'b0;
        tick(2);
        check("midreset:data", 64'(rx_data), 64'd0);
        check("midreset:valid", 64'(rx_valid), 64'd0);
        check("midreset:err", 64'(rx_err), 64'd0);
        check("midreset:busy", 64'(busy), 64'd0);
        shift_bits(64'h15, 5, 1, 1);
        rst_n = 1'b1;
        shift_bits(64'h2D, 6, 1, 1);
        check("cs_low_at_release:busy", 64'(busy), 64'd0);
        sclk = 1'b0;
        cs   = 1'b1;
        tick(2);
        exp_data = '0;
        drain("reset_abort");
        send_frame(64'h001234, 24, 1, 1, 2);
        drain("after_reset");

        send_frame(64'h000001, 24, 1, 1, 1);
        send_frame(64'h00FFFE, 24, 1, 1, 1);
        drain("back_to_back");

        for (int g = 0; g < 4; g++) begin
            for (int f = 0; f < 4; f++) begin
                logic [63:0] val;
                int          nb;
                val = {$urandom(), $urandom()};
                nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 34)) : FB;
                send_frame(val, nb, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
            end
            drain($sformatf("random_group%0d", g));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac8531_frame_receiver.md
DAC8531_FRAME_RECEIVER -- requirements
Module: dac8531_frame_receiver

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 24, giving the required number of SCLK rising edges per valid frame.
REQ-002 The block SHALL have port CLK, input, 1 bit: system clock; all logic on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: reset, synchronous, active-low; clock CLK.
REQ-004 The block SHALL have port DA_CS, input, 1 bit: frame select, active-low.
REQ-005 The block SHALL have port DA_SCLK, input, 1 bit: serial clock; data is sampled on its rising edge.
REQ-006 The block SHALL have port DA_SDI, input, 1 bit: serial data, MSB first.
REQ-007 The block SHALL have port RX_DATA, output, 24 bits: last valid frame.
REQ-008 The block SHALL have port RX_CODE, output, 16 bits: RX_DATA[15:0], the DAC code.
REQ-009 The block SHALL have port RX_PD, output, 2 bits: RX_DATA[17:16], the power-down mode.
REQ-010 The block SHALL have port RX_VALID, output, 1 bit: one-cycle pulse when a valid frame completes.
REQ-011 The block SHALL have port RX_ERR, output, 1 bit: one-cycle pulse when a frame ends with a bit count other than FRAME_BITS.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high while in state SHIFT.

Function
REQ-013 The block SHALL pass DA_CS, DA_SCLK and DA_SDI through an input stage (see Configuration), then through one history register used for edge detection.
REQ-014 The FSM SHALL have two states, IDLE and SHIFT; the reset state SHALL be IDLE.
REQ-015 In IDLE, a synchronized DA_CS falling edge SHALL clear the shift register and the bit counter and move the FSM to SHIFT.
REQ-016 In SHIFT, each synchronized DA_SCLK rising edge SHALL shift DA_SDI into the shift register LSB (shift left) and increment the 5-bit counter, which SHALL saturate at 31.
REQ-017 In SHIFT, a synchronized DA_CS rising edge SHALL return the FSM to IDLE.
REQ-018 On that CS rising edge, count==FRAME_BITS SHALL load RX_DATA from the shift register and pulse RX_VALID for 1 cycle; any other count SHALL pulse RX_ERR for 1 cycle and leave RX_DATA unchanged.
REQ-019 If a DA_SCLK rising edge and a DA_CS rising edge are detected in the same cycle, the CS edge SHALL take precedence and the SCLK edge SHALL be ignored.
REQ-020 DA_SCLK edges in IDLE SHALL be ignored.
REQ-021 RX_VALID and RX_ERR SHALL never be high in the same cycle.
REQ-022 The block SHALL decode correctly when each DA_SCLK phase and the DA_CS high time last at least 1 CLK cycle and the inputs are driven synchronously to CLK.
REQ-023 Latency: with DA_CS first sampled high at CLK edge k, RX_VALID/RX_ERR SHALL be high after edge k+2 with the macro defined and after edge k+1 without it.
REQ-024 Back-to-back frames SHALL each be received, with no dead cycles required beyond REQ-022.

Reset
REQ-025 Reset SHALL set RX_DATA=0, RX_VALID=0, RX_ERR=0, BUSY=0 and state=IDLE, and clear the counter and shift register.
REQ-026 Reset SHALL load the input and history registers with DA_CS=1, DA_SCLK=0, DA_SDI=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no RX_VALID or RX_ERR pulse.
REQ-028 If DA_CS is already low when reset is released, the block SHALL stay in IDLE until the next DA_CS falling edge.

Configuration
REQ-029 With macro DAC8531_RX_SYNC_EN defined, the input stage SHALL be two flip-flops per input (metastability protection for asynchronous sources).
REQ-030 Without DAC8531_RX_SYNC_EN, the input stage SHALL be one register per input; function is identical and latency is one cycle less (REQ-023).

Verification
REQ-031 Send 24'h00ABCD with 1-cycle SCLK phases -> one RX_VALID pulse; RX_DATA=24'h00ABCD, RX_CODE=16'hABCD, RX_PD=2'b00; RX_ERR stays 0.
REQ-032 Send 24'h03FFFF -> RX_PD=2'b11, RX_CODE=16'hFFFF, single RX_VALID.
REQ-033 Send 23 SCLK edges then raise CS -> RX_ERR pulse, no RX_VALID, RX_DATA holds its previous value.
REQ-034 Send 25 SCLK edges -> RX_ERR pulse, RX_DATA unchanged.
REQ-035 Assert RESET_N low after 10 bits, release, then send 24'h001234 -> no pulse during reset, all outputs 0 during reset, then RX_VALID with RX_DATA=24'h001234.
REQ-036 Send two frames, 24'h000001 and 24'h00FFFE, with CS high for 1 cycle between them; run with and without DAC8531_RX_SYNC_EN -> two RX_VALID pulses in order, each at the REQ-023 latency.
